handshake_rr_arbiter: RTL and testbench
=======================================

HANDSHAKE_RR_ARBITER -- requirements
Module: handshake_rr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of upstream requesters (2..8).
REQ-002 Parameter DW, default 8: data width per channel.
REQ-003 Parameter IDW, default $clog2(N_REQ): width of source-ID tag.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 valid_pre_i  input  N_REQ  per-requester valid.
REQ-007 data_pre_i  input  N_REQ*DW  per-requester data, requester i in bits [i*DW +: DW].
REQ-008 ready_pre_o  output  N_REQ  per-requester ready, at most one bit high.
REQ-009 valid_post_o  output  1  registered valid to downstream.
REQ-010 data_post_o  output  DW  registered data to downstream.
REQ-011 id_post_o  output  IDW  registered index of the source requester.
REQ-012 ready_post_i  input  1  downstream ready.
REQ-013 last_pre_i  input  N_REQ  per-requester end-of-packet flag; present only with HS_ARB_LOCK_EN.

Function
REQ-014 Transfer on a channel SHALL occur in a cycle where valid and ready are both high; there is no other handshake.
REQ-015 load = !valid_post_o || ready_post_i; the output register SHALL accept a new beat only when load is high.
REQ-016 ready_pre_o[i] SHALL equal load && gnt[i]; gnt is one-hot or zero and is computed combinationally from valid_pre_i, rr_ptr and lock state.
REQ-017 Round-robin: gnt SHALL select the first valid requester, searching from index rr_ptr upward with wrap from N_REQ-1 to 0.
REQ-018 On a transfer from requester i, rr_ptr SHALL become (i+1) mod N_REQ; without a transfer rr_ptr SHALL hold.
REQ-019 On a transfer, next cycle: valid_post_o=1, data_post_o=data of i, id_post_o=i (latency 1 cycle).
REQ-020 When load is high and gnt is zero, valid_post_o SHALL go 0; data_post_o and id_post_o SHALL hold.
REQ-021 While valid_post_o && !ready_post_i, all outputs SHALL remain stable and every ready_pre_o bit SHALL be 0.
REQ-022 Full throughput: with ready_post_i held high and requests pending, one beat SHALL transfer every cycle.
REQ-023 A requester's valid dropping without a handshake SHALL lose no state; arbitration re-evaluates every cycle.
REQ-024 A single active requester SHALL be granted every cycle, regardless of rr_ptr.

Reset
REQ-025 While rst_n=0: valid_post_o=0, data_post_o=0, id_post_o=0, rr_ptr=0, lock cleared, ready_pre_o=0.
REQ-026 Reset asserted mid-operation SHALL discard any held output beat and any packet lock; nothing is replayed after release.
REQ-027 First cycle after release SHALL arbitrate from rr_ptr=0.

Configuration
REQ-028 Macro HS_ARB_LOCK_EN: when defined, last_pre_i exists and packet locking is enabled.
REQ-029 With HS_ARB_LOCK_EN, a transfer from i with last_pre_i[i]=0 SHALL set lock to i; a transfer from i with last=1 SHALL clear lock.
REQ-030 With HS_ARB_LOCK_EN and lock set, gnt SHALL be only i (when valid_pre_i[i]); other requesters SHALL stall and the output SHALL bubble while i is invalid.
REQ-031 With HS_ARB_LOCK_EN, rr_ptr SHALL advance only on a transfer with last=1.
REQ-032 Without HS_ARB_LOCK_EN, every beat is independently arbitrated; no lock state is synthesized.

Structure
REQ-033 Package hs_pkg SHALL hold default N_REQ, DW and the IDW computation shared with other handshake blocks.
REQ-034 Grant logic SHALL be a combinational sub-module rr_arbiter (inputs req, ptr; output one-hot gnt); the registers stay in the top.

Verification
REQ-035 Reset: hold rst_n=0 with all valid_pre_i=1 -> valid_post_o=0, ready_pre_o=0; after release, first grant goes to requester 0.
REQ-036 All four valid, ready_post_i=1, data i=8'h10+i -> outputs 8'h10,11,12,13,10 on consecutive cycles, id 0,1,2,3,0.
REQ-037 Backpressure: ready_post_i=0 for 3 cycles with valid_post_o=1 -> data/id stable and ready_pre_o=0; resumes with the next RR requester.
REQ-038 Only requester 2 valid for 5 cycles -> 5 beats, id_post_o=2 each, no bubbles.
REQ-039 HS_ARB_LOCK_EN: requester 1 sends 3 beats (last on the third) with requester 0 valid throughout -> ids 1,1,1 then 0; a 1-cycle gap in requester 1 yields a bubble, not a grant to 0.
REQ-040 Reset asserted while valid_post_o=1 and lock set -> valid_post_o=0 immediately; after release, requester 0 is granted.

Source files
------------

// File: rtl/hs_pkg.sv
// Shared defaults for the handshake block family: requester count, data width
// and the source-ID width calculation.
package hs_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned DW_DEF    = 8;

  // Packet-lock state, only instantiated when HS_ARB_LOCK_EN is defined.
  typedef enum logic {
    LOCK_FREE,
    LOCK_HELD
  } lock_state_t;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first set request at or above ptr, with
// wrap-around. Output is one-hot, or zero when nothing is requested.
module rr_arbiter
  import hs_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned IDW   = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] gnt
);

  int unsigned start;
  logic        found;

  // Outer loop walks the priority order; inner loop maps that slot to a bit.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    start = 32'(ptr);
    for (int unsigned k = 0; k < N_REQ; k++) begin
      for (int unsigned j = 0; j < N_REQ; j++) begin
        if (!found && req[j] && (j == (start + k) % N_REQ)) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/handshake_rr_arbiter.sv
// N-to-1 valid/ready round-robin arbiter with a registered output stage.
// Define HS_ARB_LOCK_EN to add last_pre_i and hold the grant for whole packets.
module handshake_rr_arbiter
  import hs_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned IDW   = id_width(N_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    valid_pre_i,
  input  logic [N_REQ*DW-1:0] data_pre_i,
  output logic [N_REQ-1:0]    ready_pre_o,
  output logic                valid_post_o,
  output logic [DW-1:0]       data_post_o,
  output logic [IDW-1:0]      id_post_o,
  input  logic                ready_post_i
`ifdef HS_ARB_LOCK_EN
  ,
  input  logic [N_REQ-1:0]    last_pre_i
`endif
);

  logic             load;
  logic             xfer;
  logic             advance;
  logic [N_REQ-1:0] arb_req;
  logic [N_REQ-1:0] gnt;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   gnt_idx;
  logic [DW-1:0]    gnt_data;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr_arbiter (
    .req (arb_req),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  assign load = !valid_post_o || ready_post_i;
  // rst_n gating keeps ready low during reset, when load alone would be high.
  assign ready_pre_o = (load && rst_n) ? gnt : '0;
  assign xfer = |ready_pre_o;

  always_comb begin
    gnt_idx  = '0;
    gnt_data = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (gnt[j]) begin
        gnt_idx  = gnt_idx | IDW'(j);
        gnt_data = gnt_data | data_pre_i[j*DW +: DW];
      end
    end
  end

`ifdef HS_ARB_LOCK_EN
  lock_state_t    lock_state;
  logic [IDW-1:0] lock_id;
  logic           xfer_last;

  // gnt is one-hot, so the AND picks out the granted requester's last flag.
  assign xfer_last = |(gnt & last_pre_i);
  assign advance   = xfer && xfer_last;

  always_comb begin
    arb_req = valid_pre_i;
    if (lock_state == LOCK_HELD) begin
      arb_req = valid_pre_i & (N_REQ'(1) << lock_id);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_state <= LOCK_FREE;
      lock_id    <= '0;
    end else if (xfer) begin
      lock_state <= xfer_last ? LOCK_FREE : LOCK_HELD;
      lock_id    <= gnt_idx;
    end
  end
`else
  assign arb_req = valid_pre_i;
  assign advance = xfer;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_post_o <= 1'b0;
      data_post_o  <= '0;
      id_post_o    <= '0;
    end else if (load) begin
      valid_post_o <= |gnt;
      if (|gnt) begin
        data_post_o <= gnt_data;
        id_post_o   <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Directed bench for handshake_rr_arbiter (N_REQ=4, DW=8); the packet-lock
// scenario is compiled only when HS_ARB_LOCK_EN is defined.
module tb_handshake_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  valid_pre_i;
  logic [31:0] data_pre_i;
  logic [3:0]  ready_pre_o;
  logic        valid_post_o;
  logic [7:0]  data_post_o;
  logic [1:0]  id_post_o;
  logic        ready_post_i;
`ifdef HS_ARB_LOCK_EN
  logic [3:0]  last_pre_i;
`endif

  int checks   = 0;
  int failures = 0;

  handshake_rr_arbiter #(
    .N_REQ (4),
    .DW    (8),
    .IDW   (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_pre_i  (valid_pre_i),
    .data_pre_i   (data_pre_i),
    .ready_pre_o  (ready_pre_o),
    .valid_post_o (valid_post_o),
    .data_post_o  (data_post_o),
    .id_post_o    (id_post_o),
    .ready_post_i (ready_post_i)
`ifdef HS_ARB_LOCK_EN
    ,
    .last_pre_i   (last_pre_i)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output beat packed as {valid, id, data} for one-line comparisons.
  function automatic logic [10:0] beat();
    return {valid_post_o, id_post_o, data_post_o};
  endfunction

  task automatic test_reset();
    rst_n        = 1'b0;
    valid_pre_i  = 4'hF;
    data_pre_i   = 32'h13121110;
    ready_post_i = 1'b1;
`ifdef HS_ARB_LOCK_EN
    last_pre_i   = 4'hF;
`endif
    tick();
    tick();
    checks++;
    if (beat() !== 11'h000) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h", beat(), 11'h000);
    end
    checks++;
    if (ready_pre_o !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=%b", ready_pre_o, 4'b0000);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (ready_pre_o !== 4'b0001) begin
      failures++;
      $display("FAIL reset_first_grant got=%b exp=%b", ready_pre_o, 4'b0001);
    end
  endtask

  task automatic test_round_robin();
    logic [10:0] exp [5];
    exp[0] = {1'b1, 2'd0, 8'h10};
    exp[1] = {1'b1, 2'd1, 8'h11};
    exp[2] = {1'b1, 2'd2, 8'h12};
    exp[3] = {1'b1, 2'd3, 8'h13};
    exp[4] = {1'b1, 2'd0, 8'h10};
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (beat() !== exp[i]) begin
        failures++;
        $display("FAIL rr_beat%0d got=%h exp=%h", i, beat(), exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    ready_post_i = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ready_pre_o !== 4'b0000) begin
        failures++;
        $display("FAIL bp_ready%0d got=%b exp=%b", i, ready_pre_o, 4'b0000);
      end
      tick();
      checks++;
      if (beat() !== {1'b1, 2'd0, 8'h10}) begin
        failures++;
        $display("FAIL bp_hold%0d got=%h exp=%h", i, beat(), {1'b1, 2'd0, 8'h10});
      end
    end
    ready_post_i = 1'b1;
    #1;
    checks++;
    if (ready_pre_o !== 4'b0010) begin
      failures++;
      $display("FAIL bp_resume_ready got=%b exp=%b", ready_pre_o, 4'b0010);
    end
    tick();
    checks++;
    if (beat() !== {1'b1, 2'd1, 8'h11}) begin
      failures++;
      $display("FAIL bp_resume_beat got=%h exp=%h", beat(), {1'b1, 2'd1, 8'h11});
    end
  endtask

  task automatic test_single_requester();
    valid_pre_i = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (beat() !== {1'b1, 2'd2, 8'h12}) begin
        failures++;
        $display("FAIL single_beat%0d got=%h exp=%h", i, beat(), {1'b1, 2'd2, 8'h12});
      end
    end
    valid_pre_i = 4'b0000;
    tick();
    checks++;
    if (beat() !== {1'b0, 2'd2, 8'h12}) begin
      failures++;
      $display("FAIL idle_hold got=%h exp=%h", beat(), {1'b0, 2'd2, 8'h12});
    end
  endtask

  task automatic test_reset_mid();
    valid_pre_i = 4'b1000;
`ifdef HS_ARB_LOCK_EN
    last_pre_i  = 4'b0111;
`endif
    tick();
    checks++;
    if (beat() !== {1'b1, 2'd3, 8'h13}) begin
      failures++;
      $display("FAIL mid_pre_beat got=%h exp=%h", beat(), {1'b1, 2'd3, 8'h13});
    end
    ready_post_i = 1'b0;
    valid_pre_i  = 4'hF;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (beat() !== 11'h000) begin
      failures++;
      $display("FAIL mid_reset_outputs got=%h exp=%h", beat(), 11'h000);
    end
    ready_post_i = 1'b1;
`ifdef HS_ARB_LOCK_EN
    last_pre_i   = 4'hF;
`endif
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (ready_pre_o !== 4'b0001) begin
      failures++;
      $display("FAIL mid_release_grant got=%b exp=%b", ready_pre_o, 4'b0001);
    end
    tick();
    checks++;
    if (beat() !== {1'b1, 2'd0, 8'h10}) begin
      failures++;
      $display("FAIL mid_release_beat got=%h exp=%h", beat(), {1'b1, 2'd0, 8'h10});
    end
  endtask

`ifdef HS_ARB_LOCK_EN
  task automatic test_lock();
    logic [10:0] exp [5];
    exp[0] = {1'b1, 2'd1, 8'h11};
    exp[1] = {1'b1, 2'd1, 8'h11};
    exp[2] = {1'b0, 2'd1, 8'h11};
    exp[3] = {1'b1, 2'd1, 8'h11};
    exp[4] = {1'b1, 2'd0, 8'h10};
    for (int i = 0; i < 5; i++) begin
      valid_pre_i = (i == 2) ? 4'b0001 : 4'b0011;
      last_pre_i  = (i >= 3) ? 4'b1111 : 4'b1101;
      #1;
      if (i == 2) begin
        checks++;
        if (ready_pre_o !== 4'b0000) begin
          failures++;
          $display("FAIL lock_gap_ready got=%b exp=%b", ready_pre_o, 4'b0000);
        end
      end
      tick();
      checks++;
      if (beat() !== exp[i]) begin
        failures++;
        $display("FAIL lock_beat%0d got=%h exp=%h", i, beat(), exp[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_single_requester();
    test_reset_mid();
`ifdef HS_ARB_LOCK_EN
    test_lock();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
